// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encoding and widths shared by the reset sequencer.
// Rev 1.0
`default_nettype none

package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_REL_AXIL  = 3'd2,
    ST_REL_CORE  = 3'd3,
    ST_REL_AXIS  = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  localparam int CNT_W      = 16;
  localparam int LOSS_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_sync_2ff.sv
// sync_2ff: two-flop single-bit synchronizer, asynchronous active-low reset.
// Rev 1.0
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged, lock-qualified release of AXI-Lite, core and AXI-Stream resets.
// Rev 1.0
`default_nettype none

module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES        = 200,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 64,
  parameter int CNT_WIDTH          = CNT_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  mmcm_locked,
  input  logic                  soft_reset,
  output logic                  axil_resetn,
  output logic                  core_resetn,
  output logic                  axis_resetn,
  output logic                  seq_done,
  output logic [2:0]            seq_state,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam logic [CNT_WIDTH-1:0] C_HOLD_LAST  = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_LOCK_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_STAGE_LAST = CNT_WIDTH'(STAGE_DELAY - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  logic                  r_started;
  logic                  w_lock_s;
  logic                  w_lock_loss;

  sync_2ff u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_reset_n),
    .d     (mmcm_locked),
    .q     (w_lock_s)
  );

  assign w_lock_loss = !w_lock_s &&
                       (r_state inside {ST_REL_AXIL, ST_REL_CORE, ST_REL_AXIS, ST_RUN});

  // The first edge after reset release is the HOLD entry edge, so HOLD spans full cycles.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    if (!r_started) begin
      w_state_next = ST_HOLD;
      w_cnt_next   = '0;
    end else if (soft_reset) begin
      w_state_next = ST_HOLD;
      w_cnt_next   = '0;
    end else if (w_lock_loss) begin
      w_state_next = ST_WAIT_LOCK;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == C_HOLD_LAST) begin
            w_state_next = ST_WAIT_LOCK;
            w_cnt_next   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (!w_lock_s) begin
            w_cnt_next = '0;
          end else if (r_cnt == C_LOCK_LAST) begin
            w_state_next = ST_REL_AXIL;
            w_cnt_next   = '0;
          end
        end
        ST_REL_AXIL: begin
          if (r_cnt == C_STAGE_LAST) begin
            w_state_next = ST_REL_CORE;
            w_cnt_next   = '0;
          end
        end
        ST_REL_CORE: begin
          if (r_cnt == C_STAGE_LAST) begin
            w_state_next = ST_REL_AXIS;
            w_cnt_next   = '0;
          end
        end
        ST_REL_AXIS: begin
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
        end
        ST_RUN: begin
          w_cnt_next = '0;
        end
        default: begin
          w_state_next = ST_HOLD;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state         <= ST_HOLD;
      r_cnt           <= '0;
      r_started       <= 1'b0;
      axil_resetn     <= 1'b0;
      core_resetn     <= 1'b0;
      axis_resetn     <= 1'b0;
      seq_done        <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      r_started   <= 1'b1;
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      axil_resetn <= w_state_next inside {ST_REL_AXIL, ST_REL_CORE, ST_REL_AXIS, ST_RUN};
      core_resetn <= w_state_next inside {ST_REL_CORE, ST_REL_AXIS, ST_RUN};
      axis_resetn <= w_state_next inside {ST_REL_AXIS, ST_RUN};
      seq_done    <= (w_state_next == ST_RUN);
      if (w_lock_loss && (lock_loss_count != {LOSS_CNT_W{1'b1}})) begin
        lock_loss_count <= lock_loss_count + 1'b1;
      end
    end
  end

  assign seq_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer with shortened timing.
// Rev 1.0
`default_nettype none

module tb_reset_sequencer;

  logic        clk;
  logic        sys_reset_n;
  logic        mmcm_locked;
  logic        soft_reset;
  logic        axil_resetn;
  logic        core_resetn;
  logic        axis_resetn;
  logic        seq_done;
  logic [2:0]  seq_state;
  logic [15:0] lock_loss_count;

  int cyc;
  int passes;
  int checks;

  reset_sequencer #(
    .HOLD_CYCLES        (8),
    .LOCK_STABLE_CYCLES (16),
    .STAGE_DELAY        (4),
    .CNT_WIDTH          (16)
  ) dut (
    .sys_clk         (clk),
    .sys_reset_n     (sys_reset_n),
    .mmcm_locked     (mmcm_locked),
    .soft_reset      (soft_reset),
    .axil_resetn     (axil_resetn),
    .core_resetn     (core_resetn),
    .axis_resetn     (axis_resetn),
    .seq_done        (seq_done),
    .seq_state       (seq_state),
    .lock_loss_count (lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the rising edge numbered c.
  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  task automatic chk_resets(input string tag, input logic [3:0] exp);
    chk(tag, {axil_resetn, core_resetn, axis_resetn, seq_done}, {28'd0, exp});
  endtask

  task automatic reset_and_release(input logic lock);
    sys_reset_n = 1'b0;
    mmcm_locked = lock;
    soft_reset  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sys_reset_n = 1'b1;
    cyc = -1;
  endtask

  initial begin
    passes = 0;
    checks = 0;
    cyc    = -1;
    sys_reset_n = 1'b0;
    mmcm_locked = 1'b1;
    soft_reset  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_resets("reset_outputs", 4'b0000);
    chk("reset_state", seq_state, 0);
    chk("reset_loss_cnt", lock_loss_count, 0);

    // Clean bring-up
    @(negedge clk);
    sys_reset_n = 1'b1;
    cyc = -1;
    run_to(7);
    chk("clean_hold_c7", seq_state, 0);
    run_to(8);
    chk("clean_wait_c8", seq_state, 1);
    run_to(23);
    chk_resets("clean_c23", 4'b0000);
    run_to(24);
    chk_resets("clean_axil_c24", 4'b1000);
    chk("clean_state_c24", seq_state, 2);
    run_to(27);
    chk_resets("clean_c27", 4'b1000);
    run_to(28);
    chk_resets("clean_core_c28", 4'b1100);
    run_to(31);
    chk_resets("clean_c31", 4'b1100);
    run_to(32);
    chk_resets("clean_axis_c32", 4'b1110);
    chk("clean_state_c32", seq_state, 4);
    run_to(33);
    chk_resets("clean_done_c33", 4'b1111);
    chk("clean_state_c33", seq_state, 5);

    // Late lock: lock_s high after edge 42, release 16 samples later
    reset_and_release(1'b0);
    run_to(40);
    mmcm_locked = 1'b1;
    run_to(57);
    chk("late_state_c57", seq_state, 1);
    chk_resets("late_c57", 4'b0000);
    run_to(58);
    chk_resets("late_axil_c58", 4'b1000);
    chk("late_loss_cnt", lock_loss_count, 0);

    // Single-cycle lock glitch inside WAIT_LOCK after 10 stable samples
    reset_and_release(1'b1);
    run_to(18);
    mmcm_locked = 1'b0;
    run_to(19);
    mmcm_locked = 1'b1;
    run_to(24);
    chk_resets("glitch_no_rel_c24", 4'b0000);
    run_to(36);
    chk_resets("glitch_c36", 4'b0000);
    chk("glitch_state_c36", seq_state, 1);
    run_to(37);
    chk_resets("glitch_axil_c37", 4'b1000);
    chk("glitch_loss_cnt", lock_loss_count, 0);
    run_to(46);
    chk_resets("glitch_run_c46", 4'b1111);

    // Lock loss in RUN
    mmcm_locked = 1'b0;
    run_to(48);
    chk_resets("loss_still_run_c48", 4'b1111);
    run_to(49);
    chk_resets("loss_resets_c49", 4'b0000);
    chk("loss_state_c49", seq_state, 1);
    chk("loss_cnt_c49", lock_loss_count, 1);
    mmcm_locked = 1'b1;
    run_to(52);
    chk("loss_cnt_c52", lock_loss_count, 1);
    run_to(66);
    chk_resets("relock_c66", 4'b0000);
    run_to(67);
    chk_resets("relock_axil_c67", 4'b1000);

    // soft_reset in REL_CORE coincident with lock loss
    run_to(70);
    mmcm_locked = 1'b0;
    run_to(71);
    chk("soft_core_state_c71", seq_state, 3);
    run_to(72);
    chk_resets("soft_core_c72", 4'b1100);
    mmcm_locked = 1'b1;
    soft_reset  = 1'b1;
    run_to(73);
    soft_reset  = 1'b0;
    chk("soft_state_c73", seq_state, 0);
    chk_resets("soft_resets_c73", 4'b0000);
    chk("soft_loss_cnt_c73", lock_loss_count, 2);
    run_to(80);
    chk("soft_hold_c80", seq_state, 0);
    run_to(81);
    chk("soft_wait_c81", seq_state, 1);
    run_to(96);
    chk_resets("soft_c96", 4'b0000);
    run_to(97);
    chk_resets("soft_axil_c97", 4'b1000);
    chk("soft_loss_cnt_c97", lock_loss_count, 2);
    run_to(106);
    chk("soft_run_c106", seq_state, 5);

    // Asynchronous reset between clock edges
    #2;
    sys_reset_n = 1'b0;
    #1;
    chk_resets("async_resets", 4'b0000);
    chk("async_state", seq_state, 0);
    chk("async_loss_cnt", lock_loss_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_reset_n = 1'b1;
    cyc = -1;
    run_to(23);
    chk_resets("rebuild_c23", 4'b0000);
    run_to(24);
    chk_resets("rebuild_axil_c24", 4'b1000);
    run_to(28);
    chk_resets("rebuild_core_c28", 4'b1100);
    run_to(32);
    chk_resets("rebuild_axis_c32", 4'b1110);
    run_to(33);
    chk_resets("rebuild_done_c33", 4'b1111);
    chk("rebuild_state_c33", seq_state, 5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- First stage inside top_sim. Directly consumes the board-level active-low reset (sys_reset_n) and the MMCM lock derived from the 200 MHz reference clock.
- Produces staged, lock-qualified active-low resets for the AXI-Lite register domain, the core datapath and the AXI-Stream datapath.
- Release order is fixed (AXI-Lite first), so register access is alive before the datapath comes out of reset.
- Re-sequences automatically on MMCM lock loss or on a software reset request.

Parameters:
- HOLD_CYCLES, 200, cycles spent in HOLD after reset release or soft reset (minimum reset width seen by downstream logic).
- LOCK_STABLE_CYCLES, 1024, consecutive cycles of synchronized lock required before any release.
- STAGE_DELAY, 64, cycles between successive reset releases.
- CNT_WIDTH, 16, width of the internal stage counter; must hold max(HOLD_CYCLES, LOCK_STABLE_CYCLES, STAGE_DELAY).

Ports:
- sys_clk, in, 1, sole clock; all logic synchronous to it.
- sys_reset_n, in, 1, reset, asynchronous, active-low.
- mmcm_locked, in, 1, asynchronous MMCM lock; 2-flop synchronized internally.
- soft_reset, in, 1, single-cycle sys_clk pulse from the register block.
- axil_resetn, out, 1, AXI-Lite domain reset, active-low, registered.
- core_resetn, out, 1, core datapath reset, active-low, registered.
- axis_resetn, out, 1, AXI-Stream datapath reset, active-low, registered.
- seq_done, out, 1, high while in RUN.
- seq_state, out, 3, current state encoding.
- lock_loss_count, out, 16, saturating count of lock-loss events.

Behaviour:
- sys_reset_n low forces, asynchronously, all of the following:
  - state = HOLD, counter = 0, synchronizer flops = 0;
  - axil_resetn = core_resetn = axis_resetn = 0;
  - seq_done = 0, lock_loss_count = 0.
- Cycle 0 is the first rising edge of sys_clk with sys_reset_n high.
- The counter clears on every state entry. A state with length N exits when counter == N-1, so it lasts exactly N cycles.
- Outputs are registered from the next state: a reset deasserts on the same edge its state is entered.
- States (3-bit encoding):
  - HOLD (0): all resets 0. After HOLD_CYCLES, go to WAIT_LOCK.
  - WAIT_LOCK (1): all resets 0.
    - Counter increments while lock_s is 1; lock_s is the 2-flop synchronized lock.
    - lock_s = 0 clears the counter.
    - After LOCK_STABLE_CYCLES consecutive cycles with lock_s = 1, go to REL_AXIL.
  - REL_AXIL (2): axil_resetn = 1. After STAGE_DELAY, go to REL_CORE.
  - REL_CORE (3): axil_resetn = core_resetn = 1. After STAGE_DELAY, go to REL_AXIS.
  - REL_AXIS (4): all three resets 1. Next cycle go to RUN.
  - RUN (5): all resets 1, seq_done = 1. Remains in RUN until lock loss or soft reset.
- Default-parameter timeline with lock stable from before cycle 0:
  - axil_resetn rises at cycle 1224;
  - core_resetn rises at cycle 1288;
  - axis_resetn rises at cycle 1352;
  - seq_done rises at cycle 1353.
- Lock loss: lock_s = 0 in REL_AXIL, REL_CORE, REL_AXIS or RUN.
  - Next edge: all resets 0, seq_done 0, state WAIT_LOCK.
  - lock_loss_count increments and saturates at 16'hFFFF.
  - lock_s = 0 in HOLD or WAIT_LOCK is not counted.
- soft_reset = 1 in any state:
  - next edge: state HOLD, all resets 0, seq_done 0, counter 0;
  - a soft_reset during HOLD restarts HOLD.
- Simultaneous soft_reset and lock loss: the next state is HOLD, and lock_loss_count still increments.
- Glitch rule: resets never deassert out of order, and never deassert without a fully completed WAIT_LOCK window since the last HOLD.
- Illegal state encodings (6, 7): next state HOLD, all resets 0.
- lock_loss_count is not cleared by soft_reset; only sys_reset_n clears it.

Decomposition:
- Package reset_sequencer_pkg holds:
  - state localparams ST_HOLD=3'd0 through ST_RUN=3'd5;
  - the count width constant (16).
- One sub-module, sync_2ff: a 2-flop synchronizer with asynchronous active-low reset. It is reused for mmcm_locked and is available to other clock-crossing single bits in top_sim.

Test Plan:
All scenarios use HOLD_CYCLES=8, LOCK_STABLE_CYCLES=16, STAGE_DELAY=4.
- Clean bring-up: mmcm_locked=1 throughout, release sys_reset_n -> axil_resetn rises at cycle 24, core_resetn at 28, axis_resetn at 32, seq_done at 33, seq_state=5.
- Late lock: mmcm_locked rises at cycle 40 -> lock_s is 1 from cycle 42; axil_resetn rises at cycle 58; lock_loss_count remains 0.
- Lock glitch in WAIT_LOCK: lock low for 1 cycle after 10 stable cycles -> counter restarts; release is delayed by the glitch; count remains 0.
- Lock loss in RUN: drop mmcm_locked -> 3 cycles later (2 sync + 1 register) all resets are 0, seq_state=1, lock_loss_count=1; restore lock -> full re-sequence, axil_resetn high 16 cycles after lock_s returns to 1.
- soft_reset in REL_CORE, coincident with lock loss -> next edge state HOLD, all resets 0, lock_loss_count increments; sequence restarts with HOLD of 8 cycles.
- Async reset mid-RUN: sys_reset_n asserted between clock edges -> all outputs 0 immediately without a clock edge, lock_loss_count=0; after release the sequence matches the clean bring-up timing.
